rp_pio_cpl_tracker: RTL and testbench

RP_PIO_CPL_TRACKER -- requirements
Module: rp_pio_cpl_tracker

---
 rtl/rp_pio_pkg.sv | 54 +++++
 rtl/rp_pio_tag_entry.sv | 72 +++++++
 rtl/rp_pio_cpl_tracker.sv | 100 ++++++++++
 tb/tb_rp_pio_cpl_tracker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rp_pio_pkg.sv
// Shared types and exception-register bit positions for the RP PIO completion tracker.
package rp_pio_pkg;

  typedef enum logic [1:0] {
    REQ_CFG = 2'b00,
    REQ_IO  = 2'b01,
    REQ_MEM = 2'b10,
    REQ_ILL = 2'b11
  } req_type_e;

  typedef enum logic {
    ENT_FREE = 1'b0,
    ENT_PEND = 1'b1
  } entry_state_e;

  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_CA = 3'b100;

  localparam int EXC_CFG_UR  = 0;
  localparam int EXC_CFG_CA  = 1;
  localparam int EXC_CFG_CTO = 2;
  localparam int EXC_IO_UR   = 8;
  localparam int EXC_IO_CA   = 9;
  localparam int EXC_IO_CTO  = 10;
  localparam int EXC_MEM_UR  = 16;
  localparam int EXC_MEM_CA  = 17;
  localparam int EXC_MEM_CTO = 18;

  // Illegal request classes map to an empty mask so they never report.
  function automatic logic [31:0] exc_mask(req_type_e t, logic ur, logic ca, logic cto);
    logic [31:0] m;
    m = '0;
    case (t)
      REQ_CFG: begin
        m[EXC_CFG_UR]  = ur;
        m[EXC_CFG_CA]  = ca;
        m[EXC_CFG_CTO] = cto;
      end
      REQ_IO: begin
        m[EXC_IO_UR]  = ur;
        m[EXC_IO_CA]  = ca;
        m[EXC_IO_CTO] = cto;
      end
      REQ_MEM: begin
        m[EXC_MEM_UR]  = ur;
        m[EXC_MEM_CA]  = ca;
        m[EXC_MEM_CTO] = cto;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rp_pio_tag_entry.sv
// One outstanding-request slot: FREE/PEND state, stored class and timeout timer.
//   state    | meaning
//   ENT_FREE | slot available for allocation
//   ENT_PEND | request issued, waiting for completion or timeout
module rp_pio_tag_entry
  import rp_pio_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alloc,
  input  logic [1:0]  alloc_type,
  input  logic        tick,
  input  logic        cpl_hit,
  input  logic [2:0]  cpl_status,
  output logic        pend,
  output logic [31:0] exc
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  entry_state_e  state_q, state_d;
  req_type_e     type_q;
  logic [TW-1:0] timer_q;
  logic          expired;
  logic          is_ca;
  logic          is_ur;

  assign expired = (timer_q == TW'(TIMEOUT_TICKS));
  assign is_ca   = (cpl_status == CPL_CA);
  assign is_ur   = (cpl_status != CPL_CA) && (cpl_status != CPL_SC);
  assign pend    = (state_q == ENT_PEND);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ENT_FREE;
      type_q  <= REQ_CFG;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      if (alloc) begin
        type_q  <= req_type_e'(alloc_type);
        timer_q <= '0;
      end else if ((state_q == ENT_PEND) && tick && !expired) begin
        timer_q <= timer_q + TW'(1);
      end
    end
  end

  // A completion landing in the expiry cycle wins and suppresses the CTO.
  always_comb begin
    state_d = state_q;
    exc     = '0;
    case (state_q)
      ENT_FREE: begin
        if (alloc) state_d = ENT_PEND;
      end
      ENT_PEND: begin
        if (cpl_hit) begin
          state_d = ENT_FREE;
          exc     = exc_mask(type_q, is_ur, is_ca, 1'b0);
        end else if (expired) begin
          state_d = ENT_FREE;
          exc     = exc_mask(type_q, 1'b0, 1'b0, 1'b1);
        end
      end
      default: state_d = ENT_FREE;
    endcase
  end

endmodule

// File: rtl/rp_pio_cpl_tracker.sv
// Tracks outstanding RP PIO requests, matches completions by tag and flags timeouts
// as pulses aligned to the RP PIO exception register.
module rp_pio_cpl_tracker
  import rp_pio_pkg::*;
#(
  parameter int NUM_TAGS      = 8,
  parameter int PRESCALE      = 1024,
  parameter int TIMEOUT_TICKS = 50
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  input  logic [1:0]                  req_type,
  output logic                        req_ready,
  output logic [$clog2(NUM_TAGS)-1:0] req_tag,
  input  logic                        cpl_valid,
  input  logic [$clog2(NUM_TAGS)-1:0] cpl_tag,
  input  logic [2:0]                  cpl_status,
  output logic [31:0]                 exc_event,
  output logic                        unexp_cpl,
  output logic [$clog2(NUM_TAGS):0]   outstanding
);

  localparam int TAGW = $clog2(NUM_TAGS);
  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]       presc_q;
  logic                tick;
  logic [NUM_TAGS-1:0] pend_vec;
  logic [31:0]         entry_exc [NUM_TAGS];
  logic [31:0]         exc_d;
  logic                unexp_d;

  assign tick = (presc_q == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Allocation looks only at registered state, so a slot freed this cycle waits a cycle.
  always_comb begin
    req_ready = 1'b0;
    req_tag   = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!pend_vec[i]) begin
        req_ready = 1'b1;
        req_tag   = TAGW'(i);
      end
    end
  end

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      outstanding = outstanding + {{TAGW{1'b0}}, pend_vec[i]};
    end
  end

  for (genvar g = 0; g < NUM_TAGS; g++) begin : g_entry
    rp_pio_tag_entry #(
      .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .alloc     (req_valid && req_ready && (req_tag == TAGW'(g))),
      .alloc_type(req_type),
      .tick      (tick),
      .cpl_hit   (cpl_valid && (cpl_tag == TAGW'(g))),
      .cpl_status(cpl_status),
      .pend      (pend_vec[g]),
      .exc       (entry_exc[g])
    );
  end

  always_comb begin
    exc_d = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      exc_d = exc_d | entry_exc[i];
    end
  end

  assign unexp_d = cpl_valid && !pend_vec[cpl_tag];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exc_event <= '0;
      unexp_cpl <= 1'b0;
    end else begin
      exc_event <= exc_d;
      unexp_cpl <= unexp_d;
    end
  end

endmodule

// File: tb/tb_rp_pio_cpl_tracker.sv
// Directed scenarios plus randomized traffic against a tag/deadline reference model.
module tb_rp_pio_cpl_tracker;

  localparam int N = 8;
  localparam int P = 4;
  localparam int T = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_type = 2'b00;
  logic        req_ready;
  logic [2:0]  req_tag;
  logic        cpl_valid = 1'b0;
  logic [2:0]  cpl_tag = 3'd0;
  logic [2:0]  cpl_status = 3'd0;
  logic [31:0] exc_event;
  logic        unexp_cpl;
  logic [3:0]  outstanding;

  int checks = 0;
  int failures = 0;

  bit          m_pend [N];
  logic [1:0]  m_typ  [N];
  int          m_fire [N];
  int          cyc;
  logic [31:0] m_exc;
  bit          m_unexp;

  rp_pio_cpl_tracker #(.NUM_TAGS(N), .PRESCALE(P), .TIMEOUT_TICKS(T)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_type(req_type),
    .req_ready(req_ready), .req_tag(req_tag), .cpl_valid(cpl_valid), .cpl_tag(cpl_tag),
    .cpl_status(cpl_status), .exc_event(exc_event), .unexp_cpl(unexp_cpl),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // kind: 0 UR, 1 CA, 2 CTO; class 11 reports nothing
  function automatic logic [31:0] ref_mask(logic [1:0] t, int kind);
    logic [31:0] one;
    one = 32'h1;
    if (t == 2'b11) return 32'h0;
    return one << (int'(t) * 8 + kind);
  endfunction

  function automatic int status_kind(logic [2:0] s);
    if (s == 3'b000) return -1;
    if (s == 3'b100) return 1;
    return 0;
  endfunction

  // Cycle in which an entry allocated in cycle a is declared timed out:
  // ticks land on cycles with cyc % P == P-1, the T-th tick after a expires it next cycle.
  function automatic int fire_cycle(int a);
    int k;
    k = a + 1;
    k = k + (P - 1 - (k % P));
    return k + (T - 1) * P + 1;
  endfunction

  task automatic check_all();
    int cnt;
    int tg;
    bit rdy;
    cnt = 0;
    rdy = 0;
    tg = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_pend[i]) cnt++;
      else begin
        rdy = 1;
        tg = i;
      end
    end
    chk("req_ready", 32'(req_ready), 32'(rdy));
    if (rdy) chk("req_tag", 32'(req_tag), tg);
    chk("outstanding", 32'(outstanding), cnt);
    chk("exc_event", exc_event, m_exc);
    chk("unexp_cpl", 32'(unexp_cpl), 32'(m_unexp));
  endtask

  task automatic step(input bit rv, input logic [1:0] rt, input bit cv, input int ct,
                      input logic [2:0] cs);
    bit          done [N];
    bit          rdy;
    int          tg;
    int          k;
    logic [31:0] nexc;
    bit          nun;
    req_valid  = rv;
    req_type   = rt;
    cpl_valid  = cv;
    cpl_tag    = 3'(ct);
    cpl_status = cs;
    rdy = 0;
    tg = 0;
    for (int i = N - 1; i >= 0; i--) begin
      done[i] = 0;
      if (!m_pend[i]) begin
        rdy = 1;
        tg = i;
      end
    end
    nexc = 32'h0;
    nun = 0;
    if (cv) begin
      if (m_pend[ct]) begin
        done[ct] = 1;
        k = status_kind(cs);
        if (k >= 0) nexc |= ref_mask(m_typ[ct], k);
      end else begin
        nun = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_pend[i] && !done[i] && cyc == m_fire[i]) begin
        done[i] = 1;
        nexc |= ref_mask(m_typ[i], 2);
      end
    end
    for (int i = 0; i < N; i++) if (done[i]) m_pend[i] = 0;
    if (rv && rdy) begin
      m_pend[tg] = 1;
      m_typ[tg]  = rt;
      m_fire[tg] = fire_cycle(cyc);
    end
    m_exc = nexc;
    m_unexp = nun;
    cyc++;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(0, 2'b00, 0, 0, 3'b000);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    cpl_valid = 1'b0;
    for (int i = 0; i < N; i++) m_pend[i] = 0;
    m_exc = 32'h0;
    m_unexp = 0;
    cyc = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    int t;
    int n;
    bit seen;
    logic [2:0] cs;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_typ[i] = 2'b00;
      m_fire[i] = 0;
    end
    @(negedge clk);
    do_reset();
    chk("reset_tag", 32'(req_tag), 0);

    // MEM request, completer abort
    step(1, 2'b10, 0, 0, 3'b000);
    chk("s035_outstanding", 32'(outstanding), 1);
    idle();
    step(0, 2'b00, 1, 0, 3'b100);
    chk("s035_exc", exc_event, 32'h0002_0000);
    idle();

    // CFG request left to time out
    step(1, 2'b00, 0, 0, 3'b000);
    seen = 0;
    n = 0;
    while (!seen && n < 20) begin
      idle();
      n++;
      if (exc_event[2]) seen = 1;
    end
    chk("s036_cto_seen", 32'(seen), 1);
    chk("s036_outstanding", 32'(outstanding), 0);

    // Fill all slots, free tag 5
    for (int i = 0; i < N; i++) step(1, 2'(i % 4), 0, 0, 3'b000);
    chk("s037_ready_full", 32'(req_ready), 0);
    chk("s037_outstanding", 32'(outstanding), 8);
    step(0, 2'b00, 1, 5, 3'b000);
    chk("s037_ready", 32'(req_ready), 1);
    chk("s037_tag", 32'(req_tag), 5);

    // Drain, then completion to a free tag
    for (int i = 0; i < 16; i++) idle();
    step(0, 2'b00, 1, 3, 3'b000);
    chk("s038_unexp", 32'(unexp_cpl), 1);
    chk("s038_exc", exc_event, 32'h0);

    // IO completion UR in the exact cycle its timeout fires
    t = 0;
    for (int i = N - 1; i >= 0; i--) if (!m_pend[i]) t = i;
    step(1, 2'b01, 0, 0, 3'b000);
    while (cyc < m_fire[t]) idle();
    step(0, 2'b00, 1, t, 3'b011);
    chk("s039_exc", exc_event, 32'h0000_0100);
    idle();

    // Reset with four pending
    for (int i = 0; i < 4; i++) step(1, 2'b10, 0, 0, 3'b000);
    chk("s040_pre", 32'(outstanding), 4);
    do_reset();
    chk("s040_outstanding", 32'(outstanding), 0);
    chk("s040_exc", exc_event, 32'h0);
    chk("s040_tag", 32'(req_tag), 0);
    for (int i = 0; i < 16; i++) idle();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        case ($urandom_range(0, 3))
          0: cs = 3'b000;
          1: cs = 3'b100;
          2: cs = 3'b001;
          default: cs = 3'($urandom);
        endcase
        step(bit'($urandom_range(0, 1)), 2'($urandom), $urandom_range(0, 2) == 0,
             int'($urandom_range(0, N - 1)), cs);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
